// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TICKET,
    PAY,
    OPEN,
    CLOSE
  } state_t;

  localparam logic [1:0] TAL_CLOSED  = 2'b00;
  localparam logic [1:0] TAL_OPEN    = 2'b01;
  localparam logic [1:0] TAL_CLOSING = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: registered history bit, combinational rise output.
// History resets to 0, so an input already high after reset reports one edge.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking barrier: ticket, multi-coin payment, timed barrier, occupancy.
// Inputs act one clock after they change; T1/V1/TAL2 decode the state, D1/occ/abort are registered.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int FEE_UNITS      = 3,
  parameter int CAPACITY       = 8,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CLOSE_CYCLES   = 4,
  localparam int CNT_W   = $clog2(FEE_UNITS + 1),
  localparam int OCC_W   = $clog2(CAPACITY + 1),
  localparam int TMR_MAX = max_int(TIMEOUT_CYCLES, CLOSE_CYCLES),
  localparam int TMR_W   = $clog2(TMR_MAX + 1)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             iT,
  input  logic             iM,
  input  logic             C,
  input  logic             X,
  output logic             T1,
  output logic             V1,
  output logic [CNT_W-1:0] D1,
  output logic [1:0]       TAL2,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             abort
);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] d1_nxt;
  logic             abort_nxt;
  logic             credit;
  logic             enter;
  logic             rise_t, rise_m, rise_c, rise_x;

  edge_det u_edge_t (.clk(clk), .rst(R), .din(iT), .rise(rise_t));
  edge_det u_edge_m (.clk(clk), .rst(R), .din(iM), .rise(rise_m));
  edge_det u_edge_c (.clk(clk), .rst(R), .din(C),  .rise(rise_c));
  edge_det u_edge_x (.clk(clk), .rst(R), .din(X),  .rise(rise_x));

  assign full = (occ == OCC_W'(CAPACITY));

  always_comb begin
    state_nxt = state;
    d1_nxt    = D1;
    abort_nxt = 1'b0;
    credit    = 1'b0;
    enter     = 1'b0;
    case (state)
      IDLE: begin
        if (rise_t) begin
          if (full) abort_nxt = 1'b1;
          else      state_nxt = TICKET;
        end
      end
      TICKET: state_nxt = PAY;
      PAY: begin
        // A pulled ticket takes priority over a coin arriving in the same cycle.
        if (!iT) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          d1_nxt    = '0;
        end else if (rise_m) begin
          credit = 1'b1;
          if (D1 != CNT_W'(FEE_UNITS)) d1_nxt = D1 + CNT_W'(1);
          if (D1 + CNT_W'(1) == CNT_W'(FEE_UNITS)) state_nxt = OPEN;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          d1_nxt    = '0;
        end
      end
      OPEN: begin
        if (rise_c) begin
          enter     = 1'b1;
          state_nxt = CLOSE;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = CLOSE;
          abort_nxt = 1'b1;
        end
      end
      CLOSE: begin
        if (timer == TMR_W'(CLOSE_CYCLES - 1)) begin
          state_nxt = IDLE;
          d1_nxt    = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shared timer, restarted on any state change or credited coin; saturates while idle.
  always_comb begin
    timer_nxt = timer;
    if (state_nxt != state || credit)  timer_nxt = '0;
    else if (timer != TMR_W'(TMR_MAX)) timer_nxt = timer + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state <= IDLE;
      timer <= '0;
      D1    <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      D1    <= d1_nxt;
      abort <= abort_nxt;
    end
  end

  // Entry and exit in the same cycle cancel out.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      occ <= '0;
    end else if (enter && rise_x) begin
      occ <= occ;
    end else if (enter && !full) begin
      occ <= occ + OCC_W'(1);
    end else if (rise_x && occ != '0) begin
      occ <= occ - OCC_W'(1);
    end
  end

  assign T1   = (state == TICKET) || (state == PAY);
  assign V1   = (state == OPEN);
  assign TAL2 = (state == OPEN)  ? TAL_OPEN :
                (state == CLOSE) ? TAL_CLOSING : TAL_CLOSED;

endmodule
